hazard_fwd_unit: RTL and testbench

Pipeline hazard controller for the 5-stage CPU. It tracks destination registers of in-flight instructions through EX, MEM and WB. From that it produces registered select codes for the 4-input 32-bit EX operand muxes, and a combinational stall for load-use hazards. It sits beside the ID/EX pipeline register: it consumes ID-stage decode fields, and its select outputs drive the `op` inputs of the operand muxes.

---
 rtl/hazard_fwd_unit.sv | 109 ++++++++++
 tb/tb_hazard_fwd_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Load-use stall and EX operand-forward select generator for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add the 32-bit stall_cnt output.
module hazard_fwd_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } ex_rec_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
  } wr_rec_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // The single-bubble stall logic below only covers a one-cycle load latency.
  if (LOAD_LAT != 1) begin : g_bad_lat
    $error("hazard_fwd_unit: only LOAD_LAT=1 is supported");
  end

  ex_rec_t    ex_q, ex_d;
  wr_rec_t    mem_q, wb_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       ex_ew, mem_ew, capture;

  assign ex_ew  = ex_q.we  && (ex_q.rd  != '0);
  assign mem_ew = mem_q.we && (mem_q.rd != '0);

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] ex_rd, input logic ex_w,
                                         input logic [REG_W-1:0] mem_rd, input logic mem_w);
    if (ex_w && ex_rd == src)        return SEL_MEM;
    else if (mem_w && mem_rd == src) return SEL_WB;
    else                             return SEL_RF;
  endfunction

  assign stall   = id_valid && !flush && ex_q.load && ex_ew &&
                   ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
  assign capture = id_valid && !stall && !flush;

  always_comb begin
    ex_d    = '0;
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    if (capture) begin
      ex_d.rd   = id_rd;
      ex_d.we   = id_we;
      ex_d.load = id_load;
      // Compared against pre-shift records: EX becomes MEM, MEM becomes WB.
      fwd_a_d   = fwd_sel(id_rs, ex_q.rd, ex_ew, mem_q.rd, mem_ew);
      fwd_b_d   = fwd_sel(id_rt, ex_q.rd, ex_ew, mem_q.rd, mem_ew);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= '{rd: ex_q.rd, we: ex_q.we};
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench: stimulus pushes per-cycle expectations, a negedge monitor pops and checks.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_we, id_load, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_W(5), .LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    int         idx;
    bit         chk_s;
    logic       es;
    logic [1:0] efa, efb;
    int         ecnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, vec = 0;
  bit   done = 1'b0;

  // Drive one cycle of ID inputs and queue what must be visible during that cycle:
  // stall for these inputs, fwd for the instruction now in EX, stall_cnt (-1 = skip).
  task automatic cy(input bit r, input bit v, input int rs, input int rt, input int rd,
                    input bit we, input bit ld, input bit fl,
                    input bit cs, input bit es, input logic [1:0] fa, input logic [1:0] fb,
                    input int cnt);
    exp_t e;
    @(posedge clk); #1;
    rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_we = we; id_load = ld; flush = fl;
    vec++;
    e.idx = vec; e.chk_s = cs; e.es = es; e.efa = fa; e.efb = fb; e.ecnt = cnt;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_s) begin
          n_cmp++;
          if (stall !== e.es) begin
            n_bad++;
            $display("FAIL vec%0d stall: got %b want %b", e.idx, stall, e.es);
          end
        end
        n_cmp++;
        if (fwd_a !== e.efa) begin
          n_bad++;
          $display("FAIL vec%0d fwd_a: got %b want %b", e.idx, fwd_a, e.efa);
        end
        n_cmp++;
        if (fwd_b !== e.efb) begin
          n_bad++;
          $display("FAIL vec%0d fwd_b: got %b want %b", e.idx, fwd_b, e.efb);
        end
`ifdef HAZARD_STATS_EN
        if (e.ecnt >= 0) begin
          n_cmp++;
          if (stall_cnt !== 32'(e.ecnt)) begin
            n_bad++;
            $display("FAIL vec%0d stall_cnt: got %0d want %0d", e.idx, stall_cnt, e.ecnt);
          end
        end
`endif
      end
    end
  end

  initial begin : stim
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_we = 1'b0; id_load = 1'b0; flush = 1'b0;
    // reset with random ID activity
    cy(1, 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
       1, 0, 2'b00, 2'b00, 0);
    //  r v  rs rt rd we ld fl  cs es  fa     fb    cnt
    cy(0, 1, 3, 3, 4, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0);   // rs=rt=3 after reset
    cy(0, 1, 1, 2, 5, 1, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // add rd=5
    cy(0, 1, 5, 6, 10,1, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // sub rs=5 rt=6
    cy(0, 1, 0, 0, 7, 1, 0, 0,  1, 0, 2'b01, 2'b00, -1);  // sub sees 01/00; rd=7
    cy(0, 1, 1, 2, 11,1, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // unrelated
    cy(0, 1, 7, 1, 12,0, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // rs=7 two back
    cy(0, 1, 0, 0, 7, 1, 0, 0,  1, 0, 2'b10, 2'b00, -1);  // -> 10; rd=7 again
    cy(0, 1, 0, 0, 7, 1, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // rd=7
    cy(0, 1, 7, 7, 13,0, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // nearest must win
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b01, 2'b01, -1);
    // load-use
    cy(0, 1, 1, 2, 8, 1, 1, 0,  1, 0, 2'b00, 2'b00, -1);  // lw rd=8
    cy(0, 1, 3, 8, 14,1, 0, 0,  1, 1, 2'b00, 2'b00, -1);  // rt=8 -> stall
    cy(0, 1, 3, 8, 14,1, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // retry, bubble in EX
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b10, 1);   // retried gets fwd_b=10
    // back-to-back dependent loads
    cy(0, 1, 0, 0, 9, 1, 1, 0,  1, 0, 2'b00, 2'b00, -1);  // lw rd=9
    cy(0, 1, 9, 0, 10,1, 1, 0,  1, 1, 2'b00, 2'b00, -1);  // lw rd=10 uses 9
    cy(0, 1, 9, 0, 10,1, 1, 0,  1, 0, 2'b00, 2'b00, -1);
    cy(0, 1, 10,10,15,1, 0, 0,  1, 1, 2'b10, 2'b00, 2);   // uses 10 -> stall again
    cy(0, 1, 10,10,15,1, 0, 0,  1, 0, 2'b00, 2'b00, -1);
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b10, 2'b10, 3);
    // register 0 never matches
    cy(0, 1, 0, 0, 0, 1, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // rd=0 we=1
    cy(0, 1, 0, 0, 1, 0, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // rs=rt=0
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, -1);
    cy(0, 1, 0, 0, 0, 1, 1, 0,  1, 0, 2'b00, 2'b00, -1);  // lw rd=0
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // no stall on $0
    // flush overrides stall
    cy(0, 1, 0, 0, 8, 1, 1, 0,  1, 0, 2'b00, 2'b00, -1);  // lw rd=8
    cy(0, 1, 8, 8, 16,1, 0, 1,  1, 0, 2'b00, 2'b00, -1);  // dependent, flushed
    cy(0, 1, 8, 8, 17,0, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // EX held a bubble
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b10, 2'b10, 3);
    // id_valid=0 with matching fields
    cy(0, 1, 0, 0, 12,1, 1, 0,  1, 0, 2'b00, 2'b00, -1);  // lw rd=12
    cy(0, 0, 12,12,0, 0, 0, 0,  1, 0, 2'b00, 2'b00, -1);  // invalid: no stall
    cy(0, 1, 12,12,0, 0, 0, 0,  1, 0, 2'b00, 2'b00, -1);
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b10, 2'b10, 3);
    // reset clears in-flight load
    cy(0, 1, 0, 0, 20,1, 1, 0,  1, 0, 2'b00, 2'b00, 3);   // lw rd=20
    cy(1, 1, 0, 0, 21,1, 1, 0,  0, 0, 2'b00, 2'b00, -1);  // rst with lw rd=21 in ID
    cy(0, 1, 21,20,0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0);   // no stall, fwd cleared
    cy(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0);
    @(posedge clk); #1;
    id_valid = 1'b0;
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    n_cmp++;
    if (!done || sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: done=%0d pending=%0d want done=1 pending=0", done, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
